// File: rtl/pp_buf_ctrl.sv
// pp_buf_ctrl: ping-pong buffer controller.
//   Write side takes a valid/ready stream, steers it into bunit1/bunit2
//   (sl_din, wr_en1/wr_en2, wr_addr). Read side drains the oldest full bank
//   one word per cycle (rd_en, rd_addr, sl_dout) with out_valid/out_last
//   aligned to the one-cycle RAM read latency.
// Ports:
//   clk, rst (sync, active-high)
//   in_valid / in_ready           upstream handshake
//   sl_din, wr_en1, wr_en2, wr_addr   write steering to the bank RAMs
//   rd_en, rd_addr, sl_dout       read strobe/address/bank select
//   out_ready, out_valid, out_last    downstream handshake
//   flush                         present only with PP_FLUSH_EN
// Build option: PP_FLUSH_EN adds the flush port and per-bank length
// registers so a partially filled bank can be closed and drained.
//
// Read FSM states:
//   state  | meaning
//   R_IDLE | no bank being drained; waiting for full[sl_dout] & out_ready
//   R_READ | draining bank sl_dout; rd_en follows out_ready one cycle later
module pp_buf_ctrl #(
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  sl_din,
    output logic                  wr_en1,
    output logic                  wr_en2,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic                  rd_en,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  sl_dout,
    input  logic                  out_ready,
    output logic                  out_valid,
`ifdef PP_FLUSH_EN
    output logic                  out_last,
    input  logic                  flush
`else
    output logic                  out_last
`endif
);

    typedef enum logic {R_IDLE, R_READ} rstate_t;

    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_FULL  = (ADDR_WIDTH + 1)'(DEPTH);

    rstate_t               state_q, state_d;
    logic                  sl_din_q, sl_din_d;
    logic                  sl_dout_q, sl_dout_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [1:0]            full_q, full_d;      // index 1 = bunit1, 0 = bunit2
    logic                  rd_en_q, rd_en_d;
    logic                  out_valid_q, out_valid_d;
    logic                  out_last_q, out_last_d;

    logic                  accept;
    logic                  wr_wrap;
    logic                  rd_last;
    logic [ADDR_WIDTH:0]   rd_len;

`ifdef PP_FLUSH_EN
    logic [1:0][ADDR_WIDTH:0] len_q, len_d;
    logic                     flush_pend_q, flush_pend_d;
    logic                     flush_eff;

    assign rd_len = len_q[sl_dout_q];
`else
    assign rd_len = LEN_FULL;
`endif

    assign in_ready = ~full_q[sl_din_q];
    assign accept   = in_valid & in_ready;
    assign wr_wrap  = accept & (wr_addr_q == ADDR_LAST);
    assign rd_last  = rd_en_q & ({1'b0, rd_addr_q} == (rd_len - LEN_ONE));

    always_comb begin
        state_d     = state_q;
        sl_din_d    = sl_din_q;
        sl_dout_d   = sl_dout_q;
        wr_addr_d   = wr_addr_q;
        rd_addr_d   = rd_addr_q;
        full_d      = full_q;
        out_valid_d = rd_en_q;
        out_last_d  = rd_last;
`ifdef PP_FLUSH_EN
        len_d        = len_q;
        flush_eff    = flush | flush_pend_q;
        // A flush that collides with an accept is retried next cycle unless
        // that accept already closes the bank.
        flush_pend_d = flush_eff & accept & ~wr_wrap;
`endif

        // Write side
        if (accept) begin
            wr_addr_d = wr_addr_q + ADDR_ONE;
            if (wr_wrap) begin
                full_d[sl_din_q] = 1'b1;
                sl_din_d         = ~sl_din_q;
                wr_addr_d        = '0;
`ifdef PP_FLUSH_EN
                len_d[sl_din_q]  = LEN_FULL;
`endif
            end
        end
`ifdef PP_FLUSH_EN
        else if (flush_eff && (wr_addr_q != '0)) begin
            full_d[sl_din_q] = 1'b1;
            len_d[sl_din_q]  = {1'b0, wr_addr_q};
            sl_din_d         = ~sl_din_q;
            wr_addr_d        = '0;
        end
`endif

        // Read side; the clear always hits the other bank than a same-cycle set
        if (rd_en_q) begin
            rd_addr_d = rd_addr_q + ADDR_ONE;
            if (rd_last) begin
                full_d[sl_dout_q] = 1'b0;
                sl_dout_d         = ~sl_dout_q;
                rd_addr_d         = '0;
            end
        end

        case (state_q)
            R_IDLE: if (full_q[sl_dout_q] && out_ready) state_d = R_READ;
            R_READ: if (rd_last) state_d = full_q[~sl_dout_q] ? R_READ : R_IDLE;
            default: state_d = R_IDLE;
        endcase

        rd_en_d = (state_d == R_READ) & out_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= R_IDLE;
            sl_din_q    <= 1'b1;
            sl_dout_q   <= 1'b1;
            wr_addr_q   <= '0;
            rd_addr_q   <= '0;
            full_q      <= '0;
            rd_en_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            sl_din_q    <= sl_din_d;
            sl_dout_q   <= sl_dout_d;
            wr_addr_q   <= wr_addr_d;
            rd_addr_q   <= rd_addr_d;
            full_q      <= full_d;
            rd_en_q     <= rd_en_d;
            out_valid_q <= out_valid_d;
            out_last_q  <= out_last_d;
        end
    end

`ifdef PP_FLUSH_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            len_q        <= {2{LEN_FULL}};
            flush_pend_q <= 1'b0;
        end else begin
            len_q        <= len_d;
            flush_pend_q <= flush_pend_d;
        end
    end
`endif

    assign sl_din    = sl_din_q;
    assign sl_dout   = sl_dout_q;
    assign wr_en1    = accept & sl_din_q;
    assign wr_en2    = accept & ~sl_din_q;
    assign wr_addr   = wr_addr_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_last  = out_last_q;

endmodule
